// File: rtl/vin_frame_fmt.sv
// vin_frame_fmt: camera-to-recorder frame formatter.
// Turns vs/hs-qualified pixel beats into a tagged word stream:
// a header before each line, the line's pixels, and a trailer after each frame.
// Output goes through a small FIFO with a registered head (valid/ready).
// A write into a full FIFO drops the word, latches a sticky overflow
// and discards the rest of that frame.
module vin_frame_fmt #(
  parameter int CH_COUNT   = 10,
  parameter int PIX_W      = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int FRM_CNT_W  = 16,
  parameter int LINE_CNT_W = 12,
  parameter int PIX_CNT_W  = 12
) (
  input  logic                      p_in_clk,
  input  logic                      p_in_rst_n,
  input  logic                      p_in_en,
  input  logic [CH_COUNT*PIX_W-1:0] p_in_vd,
  input  logic                      p_in_vin_vs,
  input  logic                      p_in_vin_hs,
  output logic [CH_COUNT*PIX_W-1:0] p_out_d,
  output logic [1:0]                p_out_tag,
  output logic                      p_out_vld,
  input  logic                      p_in_rdy,
  output logic                      p_out_ovf,
  input  logic                      p_in_ovf_clr,
  output logic [FRM_CNT_W-1:0]      p_out_frm_cnt,
  output logic                      p_out_busy
);

  localparam int DW = CH_COUNT * PIX_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DW + 2;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [1:0] TAG_PIX = 2'b00;
  localparam logic [1:0] TAG_HDR = 2'b01;
  localparam logic [1:0] TAG_TRL = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LINE = 3'd1,
    ST_LINE      = 3'd2,
    ST_TRAIL     = 3'd3,
    ST_SKIP      = 3'd4
  } state_e;

  state_e                state_q, state_d, fsm_nx;
  logic                  vs_q, hs_q;
  logic [DW-1:0]         pipe_q, pipe_d;
  logic                  pipe_vld_q, pipe_vld_d, pipe_vld_nx;
  logic [PIX_CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [FRM_CNT_W-1:0]  frm_num_q, frm_num_d;
  logic [FRM_CNT_W-1:0]  frm_cnt_q, frm_cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  busy_q, busy_d;

  logic [EW-1:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         out_d_q, out_d_d;
  logic [1:0]            out_tag_q, out_tag_d;
  logic                  out_vld_q, out_vld_d;

  logic                  vs_rise, vs_fall, hs_rise;
  logic                  wr_req, push, pop, full, wr_ovf;
  logic [1:0]            wr_tag;
  logic [DW-1:0]         wr_data;

  assign vs_rise = p_in_vin_vs & ~vs_q;
  assign vs_fall = ~p_in_vin_vs & vs_q;
  assign hs_rise = p_in_vin_hs & ~hs_q;

  assign full   = (cnt_q == FULL_CNT);
  assign push   = wr_req & ~full;
  assign wr_ovf = wr_req & full;
  assign pop    = out_vld_q & p_in_rdy;

  // Capture FSM: next state, counters, pipe register and the word to write.
  always_comb begin
    fsm_nx      = state_q;
    pipe_d      = pipe_q;
    pipe_vld_nx = pipe_vld_q;
    pix_cnt_d   = pix_cnt_q;
    line_cnt_d  = line_cnt_q;
    frm_num_d   = frm_num_q;
    frm_cnt_d   = frm_cnt_q;
    wr_req      = 1'b0;
    wr_tag      = TAG_PIX;
    wr_data     = '0;
    case (state_q)
      ST_IDLE: begin
        if (vs_rise && p_in_en) begin
          fsm_nx     = ST_WAIT_LINE;
          line_cnt_d = '0;
          pix_cnt_d  = '0;
          frm_num_d  = frm_cnt_q;
          frm_cnt_d  = frm_cnt_q + FRM_CNT_W'(1);
        end else begin
          fsm_nx = ST_IDLE;
        end
      end
      ST_WAIT_LINE: begin
        if (vs_fall) begin
          fsm_nx = ST_TRAIL;
        end else if (hs_rise) begin
          wr_req      = 1'b1;
          wr_tag      = TAG_HDR;
          wr_data     = DW'({frm_num_q, line_cnt_q});
          pipe_d      = p_in_vd;
          pipe_vld_nx = 1'b1;
          pix_cnt_d   = PIX_CNT_W'(1);
          fsm_nx      = ST_LINE;
        end else begin
          fsm_nx = ST_WAIT_LINE;
        end
      end
      ST_LINE: begin
        // Every LINE cycle emits the beat held in the pipe register.
        wr_req  = pipe_vld_q;
        wr_tag  = TAG_PIX;
        wr_data = pipe_q;
        if (vs_fall) begin
          pipe_vld_nx = 1'b0;
          line_cnt_d  = line_cnt_q + LINE_CNT_W'(1);
          fsm_nx      = ST_TRAIL;
        end else if (p_in_vin_hs) begin
          pipe_d      = p_in_vd;
          pipe_vld_nx = 1'b1;
          if (pix_cnt_q != {PIX_CNT_W{1'b1}}) begin
            pix_cnt_d = pix_cnt_q + PIX_CNT_W'(1);
          end else begin
            pix_cnt_d = pix_cnt_q;
          end
        end else begin
          pipe_vld_nx = 1'b0;
          line_cnt_d  = line_cnt_q + LINE_CNT_W'(1);
          fsm_nx      = ST_WAIT_LINE;
        end
      end
      ST_TRAIL: begin
        if (!pipe_vld_q) begin
          wr_req  = 1'b1;
          wr_tag  = TAG_TRL;
          wr_data = DW'({frm_num_q, line_cnt_q, pix_cnt_q});
          fsm_nx  = ST_IDLE;
        end else begin
          fsm_nx = ST_TRAIL;
        end
      end
      ST_SKIP: begin
        pipe_vld_nx = 1'b0;
        if (!p_in_vin_vs) begin
          fsm_nx = ST_IDLE;
        end else begin
          fsm_nx = ST_SKIP;
        end
      end
      default: begin
        fsm_nx      = ST_IDLE;
        pipe_vld_nx = 1'b0;
      end
    endcase
  end

  // Overflow overrides the FSM: abandon the frame and flag it.
  always_comb begin
    if (wr_ovf) begin
      state_d    = ST_SKIP;
      pipe_vld_d = 1'b0;
      ovf_d      = 1'b1;
    end else begin
      state_d    = fsm_nx;
      pipe_vld_d = pipe_vld_nx;
      ovf_d      = p_in_ovf_clr ? 1'b0 : ovf_q;
    end
  end

  // FIFO bookkeeping and next value of the registered head word.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
    out_d_d   = out_d_q;
    out_tag_d = out_tag_q;
    if (cnt_d == '0) begin
      out_vld_d = 1'b0;
    end else if (push && (wr_ptr_q == rd_ptr_d)) begin
      // The new head is the word being written this cycle.
      out_vld_d = 1'b1;
      out_d_d   = wr_data;
      out_tag_d = wr_tag;
    end else begin
      out_vld_d = 1'b1;
      out_d_d   = mem_q[rd_ptr_d][DW-1:0];
      out_tag_d = mem_q[rd_ptr_d][EW-1:DW];
    end
    busy_d = (state_d != ST_IDLE) || (cnt_d != '0);
  end

  // Control, capture and output state registers.
  always_ff @(posedge p_in_clk or negedge p_in_rst_n) begin
    if (!p_in_rst_n) begin
      state_q    <= ST_IDLE;
      // Seen as already high so a frame running across reset is not
      // mistaken for a new frame start.
      vs_q       <= 1'b1;
      hs_q       <= 1'b0;
      pipe_q     <= '0;
      pipe_vld_q <= 1'b0;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      frm_num_q  <= '0;
      frm_cnt_q  <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      out_d_q    <= '0;
      out_tag_q  <= 2'b00;
      out_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      vs_q       <= p_in_vin_vs;
      hs_q       <= p_in_vin_hs;
      pipe_q     <= pipe_d;
      pipe_vld_q <= pipe_vld_d;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      frm_num_q  <= frm_num_d;
      frm_cnt_q  <= frm_cnt_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      out_d_q    <= out_d_d;
      out_tag_q  <= out_tag_d;
      out_vld_q  <= out_vld_d;
    end
  end

  // FIFO storage array.
  always_ff @(posedge p_in_clk or negedge p_in_rst_n) begin
    if (!p_in_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= {wr_tag, wr_data};
    end
  end

  assign p_out_d       = out_d_q;
  assign p_out_tag     = out_tag_q;
  assign p_out_vld     = out_vld_q;
  assign p_out_ovf     = ovf_q;
  assign p_out_frm_cnt = frm_cnt_q;
  assign p_out_busy    = busy_q;

endmodule

// File: tb/tb_vin_frame_fmt.sv
// Directed bench for vin_frame_fmt: drives frames, collects the word stream
// and compares it against hand-computed header/pixel/trailer words.
module tb_vin_frame_fmt;

  localparam int DW = 80;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, vs, hs, rdy, ovf_clr;
  logic [DW-1:0] vd;
  logic [DW-1:0] d;
  logic [1:0]    tag;
  logic          vld, ovf, busy;
  logic [15:0]   frm_cnt;

  int checks = 0;
  int failures = 0;
  logic [81:0] got_q[$];
  logic [81:0] exp_q[$];

  always #5 clk = ~clk;

  vin_frame_fmt dut (
    .p_in_clk      (clk),
    .p_in_rst_n    (rst_n),
    .p_in_en       (en),
    .p_in_vd       (vd),
    .p_in_vin_vs   (vs),
    .p_in_vin_hs   (hs),
    .p_out_d       (d),
    .p_out_tag     (tag),
    .p_out_vld     (vld),
    .p_in_rdy      (rdy),
    .p_out_ovf     (ovf),
    .p_in_ovf_clr  (ovf_clr),
    .p_out_frm_cnt (frm_cnt),
    .p_out_busy    (busy)
  );

  // Record every accepted word, sampled half a cycle before the pop edge.
  always @(negedge clk) begin
    if (rst_n && vld && rdy) got_q.push_back({tag, d});
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic pe(input logic [1:0] t, input logic [DW-1:0] w);
    exp_q.push_back({t, w});
  endtask

  task automatic check_stream(input string name);
    chk({name, "_len"}, 128'(got_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s[%0d]", name, i), 128'(got_q[i]), 128'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  // One frame of nl lines, nb beats each, 1-cycle hs gaps; beat value (l<<4)+b+1.
  task automatic run_frame(input logic en_v, input int nl, input int nb);
    en = en_v; vs = 1'b1;
    idle(2);
    for (int l = 0; l < nl; l++) begin
      for (int b = 0; b < nb; b++) begin
        hs = 1'b1; vd = DW'(l * 16 + b + 1);
        step();
      end
      hs = 1'b0; vd = '0;
      step();
    end
    vs = 1'b0;
    idle(7);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; vs = 1'b0; hs = 1'b0; rdy = 1'b1; ovf_clr = 1'b0; vd = '0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Reset / idle state
    chk("rst_vld", 128'(vld), 128'(0));
    chk("rst_d", 128'(d), 128'(0));
    chk("rst_tag", 128'(tag), 128'(0));
    chk("rst_ovf", 128'(ovf), 128'(0));
    chk("rst_frm_cnt", 128'(frm_cnt), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));

    // Frame 0: one line of 4 beats, header latency checked explicitly
    en = 1'b1; vs = 1'b1;
    idle(2);
    hs = 1'b1; vd = 80'h1;
    step();
    chk("hdr_lat_vld", 128'(vld), 128'(1));
    chk("hdr_lat_tag", 128'(tag), 128'(1));
    vd = 80'h2; step();
    vd = 80'h3; step();
    vd = 80'h4; step();
    hs = 1'b0; vd = '0;
    idle(2);
    vs = 1'b0;
    idle(7);
    pe(2'b01, 80'h0);
    pe(2'b00, 80'h1); pe(2'b00, 80'h2); pe(2'b00, 80'h3); pe(2'b00, 80'h4);
    pe(2'b10, 80'h1004);
    check_stream("f0");
    chk("f0_frm_cnt", 128'(frm_cnt), 128'(1));
    chk("f0_busy", 128'(busy), 128'(0));

    // Frame 1: three lines of 2 beats, back-to-back
    run_frame(1'b1, 3, 2);
    pe(2'b01, 80'h1000); pe(2'b00, 80'h01); pe(2'b00, 80'h02);
    pe(2'b01, 80'h1001); pe(2'b00, 80'h11); pe(2'b00, 80'h12);
    pe(2'b01, 80'h1002); pe(2'b00, 80'h21); pe(2'b00, 80'h22);
    pe(2'b10, 80'h1003002);
    check_stream("f1");
    chk("f1_frm_cnt", 128'(frm_cnt), 128'(2));

    // Frame 2: rdy low for a 20-beat line -> overflow, frame discarded
    rdy = 1'b0; en = 1'b1; vs = 1'b1;
    idle(2);
    for (int i = 1; i <= 20; i++) begin
      hs = 1'b1; vd = DW'(i);
      step();
    end
    hs = 1'b0; vd = '0; step();
    vs = 1'b0;
    idle(4);
    chk("f2_ovf", 128'(ovf), 128'(1));
    chk("f2_hold_vld", 128'(vld), 128'(1));
    chk("f2_hold_tag", 128'(tag), 128'(1));
    chk("f2_hold_d", 128'(d), 128'h2000);
    chk("f2_busy", 128'(busy), 128'(1));
    rdy = 1'b1;
    idle(24);
    pe(2'b01, 80'h2000);
    for (int i = 1; i <= 15; i++) pe(2'b00, DW'(i));
    check_stream("f2_drain");
    chk("f2_empty_vld", 128'(vld), 128'(0));
    chk("f2_frm_cnt", 128'(frm_cnt), 128'(3));
    ovf_clr = 1'b1; step();
    ovf_clr = 1'b0;
    chk("ovf_clr", 128'(ovf), 128'(0));

    // Frame 3: normal after overflow
    run_frame(1'b1, 1, 1);
    pe(2'b01, 80'h3000); pe(2'b00, 80'h01); pe(2'b10, 80'h3001001);
    check_stream("f3");

    // en=0 at vs rise: nothing emitted, counter unchanged
    run_frame(1'b0, 1, 3);
    check_stream("en0");
    chk("en0_frm_cnt", 128'(frm_cnt), 128'(4));
    chk("en0_busy", 128'(busy), 128'(0));

    // Frame 4: hs already high at vs rise -> partial line ignored
    en = 1'b1; hs = 1'b1; vd = 80'h55;
    idle(2);
    vs = 1'b1;
    idle(2);
    hs = 1'b0; vd = '0; step();
    hs = 1'b1; vd = 80'h66; step();
    vd = 80'h67; step();
    hs = 1'b0; vd = '0; step();
    vs = 1'b0;
    idle(7);
    pe(2'b01, 80'h4000); pe(2'b00, 80'h66); pe(2'b00, 80'h67); pe(2'b10, 80'h4001002);
    check_stream("f4");

    // Frame 5: overflow in the same cycle as ovf_clr -> set wins
    rdy = 1'b0; vs = 1'b1;
    idle(2);
    for (int i = 1; i <= 20; i++) begin
      hs = 1'b1; vd = DW'(i);
      ovf_clr = (i == 17);
      if (i == 17) chk("f5_ovf_before", 128'(ovf), 128'(0));
      step();
      if (i == 17) chk("f5_ovf_set_wins", 128'(ovf), 128'(1));
    end
    ovf_clr = 1'b0; hs = 1'b0; vd = '0; step();
    vs = 1'b0;
    idle(3);
    rdy = 1'b1;
    idle(24);
    pe(2'b01, 80'h5000);
    for (int i = 1; i <= 15; i++) pe(2'b00, DW'(i));
    check_stream("f5_drain");
    chk("f5_frm_cnt", 128'(frm_cnt), 128'(6));

    // Reset mid-line, vs held high across reset
    vs = 1'b1;
    idle(2);
    hs = 1'b1; vd = 80'h1; step();
    vd = 80'h2; step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 128'(vld), 128'(0));
    chk("mid_rst_ovf", 128'(ovf), 128'(0));
    chk("mid_rst_frm_cnt", 128'(frm_cnt), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    idle(2);
    got_q.delete();
    rst_n = 1'b1;
    hs = 1'b0; step();
    hs = 1'b1; vd = 80'h9; idle(2);
    hs = 1'b0; vd = '0; idle(4);
    check_stream("post_rst_quiet");
    chk("post_rst_busy", 128'(busy), 128'(0));
    vs = 1'b0;
    idle(2);
    run_frame(1'b1, 1, 2);
    pe(2'b01, 80'h0); pe(2'b00, 80'h01); pe(2'b00, 80'h02); pe(2'b10, 80'h1002);
    check_stream("post_rst_f0");
    chk("post_rst_frm_cnt", 128'(frm_cnt), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vin_frame_fmt.md
# vin_frame_fmt

Parametrised video-input frame formatter between the camera capture path and the HDD recording core. It accepts CH_COUNT parallel pixel channels qualified by frame (vs) and line (hs) strobes. It emits a tagged word stream: one header word before each line, the line's pixel beats, and a trailer word after each frame. Output is through an internal FIFO with valid/ready back-pressure, sticky overflow reporting and whole-frame discard on overflow.

## Interface
- CH_COUNT, 10: parallel pixel channels; DW = CH_COUNT*PIX_W
- PIX_W, 8: bits per channel pixel
- FIFO_DEPTH, 16: FIFO entries; power of 2, >= 4
- FRM_CNT_W, 16: frame counter width
- LINE_CNT_W, 12: line counter width
- PIX_CNT_W, 12: beats-per-line counter width; DW >= PIX_CNT_W+LINE_CNT_W+FRM_CNT_W

Ports:
- p_in_clk  in  1  sole clock
- p_in_rst_n  in  1  asynchronous, active-low reset
- p_in_en  in  1  capture enable; sampled only at vs rising edge
- p_in_vd  in  DW  pixel beat, channel 0 in LSBs
- p_in_vin_vs  in  1  frame active (level)
- p_in_vin_hs  in  1  beat valid; a line is a contiguous run of hs=1 inside a frame
- p_out_d  out  DW  output word
- p_out_tag  out  2  00 pixel, 01 line header, 10 frame trailer
- p_out_vld  out  1  p_out_d/p_out_tag valid
- p_in_rdy  in  1  consumer accepts word when vld&rdy
- p_out_ovf  out  1  sticky overflow flag
- p_in_ovf_clr  in  1  clears p_out_ovf
- p_out_frm_cnt  out  FRM_CNT_W  accepted frames since reset
- p_out_busy  out  1  FSM not IDLE or FIFO not empty

## Operation
- Edge detect vs/hs against 1-cycle registered copies.
- FSM states:
  - IDLE: on vs rise with en=1, go to WAIT_LINE, clear line counter, latch frame number = p_out_frm_cnt, and increment p_out_frm_cnt (wraps). On vs rise with en=0, stay in IDLE.
  - WAIT_LINE: on hs rise, write header, load beat into the pipe register, pix_cnt=1, go to LINE. On vs fall, go to TRAIL.
  - LINE: each hs=1 cycle, write the pipe register to the FIFO as a pixel and reload it. On hs fall, write the last pipe beat, then line counter +1 (wraps), go to WAIT_LINE. On vs fall, do the same flush, then go to TRAIL.
  - TRAIL: write the trailer once the pipe register is empty, go to IDLE.
  - SKIP: discard everything; go to IDLE on vs low.
- The pipe register delays pixels one cycle, so the header precedes the first pixel.
- Header word: [LINE_CNT_W-1:0] line index; next FRM_CNT_W bits frame number; upper bits 0.
- Trailer word: [PIX_CNT_W-1:0] beats of last line; next LINE_CNT_W bits line count; next FRM_CNT_W bits frame number; upper bits 0.
- pix_cnt saturates at all ones.
- A line already in progress at vs rise (hs=1) is ignored until the next hs rise.
- hs outside a frame is ignored.
- FIFO full is count==FIFO_DEPTH, evaluated on registered count; a same-cycle read does not free space for that write.
- Overflow (any write while full):
  - the entry is dropped and ovf is set;
  - the FSM goes to SKIP, so no further headers, pixels or trailer are written for that frame;
  - entries already queued still drain.
- ovf set and clr in the same cycle: set wins.
- Reset mid-frame: all state cleared; capture resumes only at the next vs rise.

## Timing
- Reset values: p_out_d=0, p_out_tag=0, p_out_vld=0, p_out_ovf=0, p_out_frm_cnt=0, p_out_busy=0, FSM=IDLE, FIFO empty.
- FIFO write in cycle t is visible on p_out_vld at t+1 (registered first-word fall-through).
- Pixel latency: hs beat at cycle t is written at t+1 and visible at t+2. Header is written at t, visible at t+1.
- While vld=1 and rdy=0, d and tag stay stable.
- Pop occurs on vld&rdy. With rdy held high, one word per cycle.
- Line gap minimum is 1 cycle of hs=0; back-to-back lines are lossless given FIFO space.
- The trailer is written 1 cycle after the final pipe flush. If vs falls in WAIT_LINE, it is written on the fall cycle + 1.

## Test plan
- Reset then idle: all outputs 0, busy=0.
- vs rise with en=1, one line of 4 beats (0x..01..04), vs fall, rdy=1.
  - Expected stream: header tag01 (line 0, frame 0); pixels 01..04 tag00; trailer tag10 (pix=4, lines=1, frame 0).
  - p_out_frm_cnt=1.
- Three lines of 2 beats with 1-cycle hs gaps, second frame.
  - Headers carry line 0/1/2 and frame 1.
  - Trailer lines=3; no gaps lost.
- rdy=0 for whole frame of 20 beats, FIFO_DEPTH=16.
  - 16 entries queued, ovf=1, no trailer.
  - Releasing rdy drains exactly 16 words; the next frame is formatted normally.
- en=0 at vs rise: no output, frm_cnt unchanged.
- hs high at vs rise: partial line ignored. Then ovf_clr asserted with an overflow in the same cycle: ovf stays 1.
- Reset asserted mid-line: vld=0 immediately; the next full frame is emitted as frame 0.
